// File: rtl/mem_bus_unit.sv
//----------------------------------------------------------------------------
// mem_bus_unit
// Memory stage between EX and WB. Issues one registered bus transaction per
// load/store (MIPS32 big-endian lanes, LWL/LWR/SWL/SWR merging, LL/SC),
// stalls the pipeline while the bus is busy, and reports alignment, bus-error
// and timeout exceptions. Non-memory ops pass through with zero latency.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   valid_i, aluop, mem_addr,   op from EX (held stable while stall_req=1)
//   opv2
//   we, waddr, wdata            EX writeback request
//   flush, llbit_clr            kill writeback / clear LLbit
//   we_o, waddr_o, wdata_o      writeback to WB
//   stall_req                   pipeline hold
//   bus_req/we/addr/sel/wdata   registered bus request
//   bus_ack, bus_err, bus_rdata bus response
//   exc_o, exc_code, badvaddr_o exception report (1 AdEL, 2 AdES, 3 bus err)
//   llbit_o                     current LLbit
//
// state | meaning
// IDLE  | accept op; pass-through, immediate exceptions, SC fail
// BUSY  | bus_req held until ack, error or timeout
// DONE  | one-cycle writeback / exception report
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_bus_unit #(
    parameter int unsigned TIMEOUT     = 255,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter bit          LLBIT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  aluop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] opv2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        flush,
    input  logic        llbit_clr,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        stall_req,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        exc_o,
    output logic [1:0]  exc_code,
    output logic [31:0] badvaddr_o,
    output logic        llbit_o
);
    localparam logic [7:0] OP_LB  = 8'h20, OP_LH  = 8'h21, OP_LWL = 8'h22,
                           OP_LW  = 8'h23, OP_LBU = 8'h24, OP_LHU = 8'h25,
                           OP_LWR = 8'h26, OP_SB  = 8'h28, OP_SH  = 8'h29,
                           OP_SWL = 8'h2A, OP_SW  = 8'h2B, OP_SWR = 8'h2E,
                           OP_LL  = 8'h30, OP_SC  = 8'h38;
    localparam int unsigned TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic        req_q, we_q;
    logic [31:0] addr_bus_q, wdata_bus_q;
    logic [3:0]  sel_q;
    logic [7:0]  op_q;
    logic [31:0] addr_q, opv2_q, rdata_q, cnt;
    logic        fail_q, kill_q, llbit_q;

    logic        is_half, is_word, is_part, is_store, is_mem;
    logic        misalign, sc_skip, start, timeout_hit, commit;
    logic [3:0]  sel_n;
    logic [31:0] wdata_n, addr_n, rshift, load_data;
    logic [4:0]  sh, bsh;

    // Op decode and lane/data steering for the request about to be issued.
    always_comb begin
        is_half  = aluop inside {OP_LH, OP_LHU, OP_SH};
        is_word  = aluop inside {OP_LW, OP_SW, OP_LL, OP_SC};
        is_part  = aluop inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR};
        is_store = aluop inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_SC};
        is_mem   = is_half || is_word || is_part ||
                   (aluop inside {OP_LB, OP_LBU, OP_SB});
        misalign = ALIGN_CHECK && ((is_half && mem_addr[0]) ||
                                   (is_word && (mem_addr[1:0] != 2'b00)));
        sc_skip  = (aluop == OP_SC) && !(LLBIT_EN && llbit_q);
        start    = valid_i && is_mem && !flush && !misalign && !sc_skip;

        sel_n   = 4'b1111;
        wdata_n = opv2;
        addr_n  = is_part ? {mem_addr[31:2], 2'b00} : mem_addr;
        case (aluop)
            OP_LB, OP_LBU: sel_n = 4'b1000 >> mem_addr[1:0];
            OP_SB: begin
                sel_n   = 4'b1000 >> mem_addr[1:0];
                wdata_n = {4{opv2[7:0]}};
            end
            OP_LH, OP_LHU: sel_n = mem_addr[1] ? 4'b0011 : 4'b1100;
            OP_SH: begin
                sel_n   = mem_addr[1] ? 4'b0011 : 4'b1100;
                wdata_n = {2{opv2[15:0]}};
            end
            OP_LWL: sel_n = 4'b1111 >> mem_addr[1:0];
            OP_LWR: sel_n = 4'b1111 << (2'd3 - mem_addr[1:0]);
            OP_SWL: begin
                sel_n   = 4'b1111 >> mem_addr[1:0];
                wdata_n = opv2 >> {mem_addr[1:0], 3'b000};
            end
            OP_SWR: begin
                sel_n   = 4'b1111 << (2'd3 - mem_addr[1:0]);
                wdata_n = opv2 << {~mem_addr[1:0], 3'b000};
            end
            default: ;
        endcase
    end

    // Load formatting from captured read data; bsh = 8*(3-offset).
    always_comb begin
        sh     = {addr_q[1:0], 3'b000};
        bsh    = {~addr_q[1:0], 3'b000};
        rshift = rdata_q >> bsh;
        case (op_q)
            OP_LB:  load_data = {{24{rshift[7]}}, rshift[7:0]};
            OP_LBU: load_data = {24'd0, rshift[7:0]};
            OP_LH:  load_data = addr_q[1] ? {{16{rdata_q[15]}}, rdata_q[15:0]}
                                          : {{16{rdata_q[31]}}, rdata_q[31:16]};
            OP_LHU: load_data = addr_q[1] ? {16'd0, rdata_q[15:0]}
                                          : {16'd0, rdata_q[31:16]};
            OP_LW, OP_LL: load_data = rdata_q;
            OP_LWL: load_data = (rdata_q << sh) | (opv2_q & ~(32'hFFFF_FFFF << sh));
            OP_LWR: load_data = rshift | (opv2_q & ~(32'hFFFF_FFFF >> bsh));
            OP_SC:  load_data = 32'd1;
            default: load_data = 32'd0;
        endcase
    end

    // An ack seen together with the last timeout cycle still counts as success.
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TLIM);
    assign commit      = (state == DONE) && !fail_q && !kill_q && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_bus_q  <= '0;
            sel_q       <= '0;
            wdata_bus_q <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            opv2_q      <= '0;
            rdata_q     <= '0;
            cnt         <= '0;
            fail_q      <= 1'b0;
            kill_q      <= 1'b0;
            llbit_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= BUSY;
                    req_q       <= 1'b1;
                    we_q        <= is_store;
                    addr_bus_q  <= addr_n;
                    sel_q       <= sel_n;
                    wdata_bus_q <= wdata_n;
                    op_q        <= aluop;
                    addr_q      <= mem_addr;
                    opv2_q      <= opv2;
                    cnt         <= '0;
                    fail_q      <= 1'b0;
                    kill_q      <= 1'b0;
                end
                BUSY: begin
                    kill_q <= kill_q | flush;
                    if (bus_ack || bus_err || timeout_hit) begin
                        state   <= DONE;
                        req_q   <= 1'b0;
                        rdata_q <= bus_rdata;
                        fail_q  <= bus_err || !bus_ack;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (llbit_clr)
                llbit_q <= 1'b0;
            else if (commit && op_q == OP_LL)
                llbit_q <= LLBIT_EN;
            else if (commit && op_q == OP_SC)
                llbit_q <= 1'b0;
        end
    end

    // Every output is forced low while reset is held, registered ones included.
    always_comb begin
        we_o       = 1'b0;
        waddr_o    = '0;
        wdata_o    = '0;
        stall_req  = 1'b0;
        exc_o      = 1'b0;
        exc_code   = 2'd0;
        badvaddr_o = '0;
        if (!rst) begin
            waddr_o = waddr;
            wdata_o = wdata;
            case (state)
                IDLE: begin
                    if (!valid_i || !is_mem) begin
                        we_o = we && !flush;
                    end else if (flush) begin
                        we_o = 1'b0;
                    end else if (misalign) begin
                        exc_o      = 1'b1;
                        exc_code   = is_store ? 2'd2 : 2'd1;
                        badvaddr_o = mem_addr;
                    end else if (sc_skip) begin
                        we_o    = we;
                        wdata_o = '0;
                    end else begin
                        stall_req = 1'b1;
                    end
                end
                BUSY: stall_req = 1'b1;
                default: begin
                    wdata_o = load_data;
                    if (fail_q) begin
                        exc_o      = 1'b1;
                        exc_code   = 2'd3;
                        badvaddr_o = addr_q;
                    end else begin
                        we_o = we && !kill_q && !flush;
                    end
                end
            endcase
        end
    end

    assign bus_req   = req_q & ~rst;
    assign bus_we    = we_q & ~rst;
    assign bus_addr  = rst ? '0 : addr_bus_q;
    assign bus_sel   = rst ? '0 : sel_q;
    assign bus_wdata = rst ? '0 : wdata_bus_q;
    assign llbit_o   = llbit_q & ~rst;

endmodule

// File: doc/mem_bus_unit.md
MEM_BUS_UNIT -- requirements
Module: mem_bus_unit

Interface
REQ-001 Parameter TIMEOUT, 255, bus-wait cycles before abort; 0 disables timeout.
REQ-002 Parameter ALIGN_CHECK, 1, 1 enables address-alignment exceptions.
REQ-003 Parameter LLBIT_EN, 1, 1 implements LL/SC; 0 makes SC always fail.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 valid_i  in  1 / aluop  in  8 / mem_addr  in  32 / opv2  in  32  op from EX; held stable by upstream while stall_req=1.
REQ-007 we  in  1 / waddr  in  5 / wdata  in  32  EX writeback request.
REQ-008 flush  in  1  kill current op's writeback; llbit_clr  in  1  clear LLbit (exception/ERET).
REQ-009 we_o  out  1 / waddr_o  out  5 / wdata_o  out  32  writeback to WB.
REQ-010 stall_req  out  1  pipeline hold request.
REQ-011 bus_req  out  1 / bus_we  out  1 / bus_addr  out  32 / bus_sel  out  4 / bus_wdata  out  32  registered bus request.
REQ-012 bus_ack  in  1 / bus_err  in  1 / bus_rdata  in  32  bus response.
REQ-013 exc_o  out  1 / exc_code  out  2 (1 AdEL, 2 AdES, 3 bus error) / badvaddr_o  out  32  exception report.
REQ-014 llbit_o  out  1  current LLbit.

Function
REQ-015 FSM states IDLE, BUSY, DONE.
REQ-016 Non-memory op in IDLE: we_o/waddr_o/wdata_o = we/waddr/wdata combinationally, stall_req=0, zero latency.
REQ-017 Memory op (LB,LBU,LH,LHU,LW,LWL,LWR,SB,SH,SW,SWL,SWR,LL, SC with LLbit=1) with valid_i in IDLE, no exception: stall_req=1 same cycle; next cycle BUSY with bus_req=1 and bus_addr/sel/we/wdata latched.
REQ-018 Big-endian lanes: addr[1:0]=00 -> byte [31:24], sel 1000; 11 -> [7:0], sel 0001; halfword 00 -> sel 1100, 10 -> sel 0011; word sel 1111.
REQ-019 SB replicates opv2[7:0] x4; SH replicates opv2[15:0] x2; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-020 LWL/LWR/SWL/SWR: bus_addr = {mem_addr[31:2],2'b00}, sel/merge with opv2 per MIPS32 big-endian unaligned rules.
REQ-021 BUSY: bus_req held with constant fields until bus_ack or bus_err; stall_req=1.
REQ-022 bus_ack in BUSY: capture bus_rdata, bus_req=0 next cycle, go DONE.
REQ-023 DONE (one cycle): stall_req=0, we_o=we, wdata_o = formatted load data (stores: 0; SC: 1); then IDLE.
REQ-024 bus_err in BUSY, or TIMEOUT cycles elapsed in BUSY: drop bus_req, go DONE with we_o=0, exc_o=1, exc_code=3, badvaddr_o=mem_addr.
REQ-025 ALIGN_CHECK=1: halfword op with addr[0]=1 or LW/SW/LL/SC with addr[1:0]!=0 -> no bus cycle, no stall, same-cycle exc_o=1, code 1 (loads) / 2 (stores), badvaddr_o=mem_addr, we_o=0.
REQ-026 exc_o is 0 except in the reporting cycle.
REQ-027 LL completion sets LLbit; SC completion clears LLbit and writes 1; SC with LLbit=0: no bus cycle, no stall, wdata_o=0, we_o=we.
REQ-028 llbit_clr same cycle as LL completion: clear wins.
REQ-029 flush in IDLE: we_o=0, no bus cycle; flush during BUSY: transaction runs to ack/err/timeout, DONE suppresses we_o and LLbit update.
REQ-030 Timeout counter cleared on entering BUSY; never wraps.

Reset
REQ-031 rst=1 on a clock edge: state IDLE, LLbit=0, counter=0, all registered outputs 0.
REQ-032 While rst=1 all outputs read 0 (bus_req, stall_req, we_o, exc_o included).
REQ-033 rst asserted during BUSY: bus_req=0 from next cycle, no writeback, no exception.

Verification
REQ-034 LB addr 0x1001, bus_rdata 0x00F00000, ack after 3 cycles -> bus_sel 0100, stall 4 cycles, DONE wdata_o=0xFFFFFFF0.
REQ-035 SH addr 0x2002, opv2 0x1234ABCD -> bus_sel 0011, bus_wdata 0xABCDABCD, bus_we=1, DONE we_o=we.
REQ-036 LW addr 0x3001 -> no bus_req, exc_o=1, exc_code=1, badvaddr_o=0x3001, stall_req=0.
REQ-037 LL 0x40 (ack) then SC 0x40 -> SC bus cycle, wdata_o=1, llbit_o=0; second SC -> no bus cycle, wdata_o=0.
REQ-038 TIMEOUT=4, LW with no ack -> bus_req drops after 4 BUSY cycles, exc_code=3, we_o=0.
REQ-039 flush during BUSY of LW then ack -> DONE we_o=0, FSM returns IDLE.
